// File: rtl/alu_exec_unit.sv
// ALU control decode plus execute stage: single-cycle RV32I ops, iterative RV32M
// multiply/divide, results leaving through a valid/ready handshake.
module alu_exec_unit #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [3:0]      funct,
    input  logic            funct_m,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [3:0]      alu_ctrl,
    output logic            zero,
    output logic            lt,
    output logic            ltu,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN) + 1;

    localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_XOR  = 4'b0010, C_LSL  = 4'b0011;
    localparam logic [3:0] C_RSL = 4'b0100, C_RSA = 4'b0101, C_ADD  = 4'b0110, C_SUB  = 4'b0111;
    localparam logic [3:0] C_SLT = 4'b1000, C_SLTU = 4'b1001, C_PASSB = 4'b1010, C_MUL = 4'b1011;
    localparam logic [3:0] C_DIV = 4'b1100, C_NONE = 4'b1111;

    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;

    logic [1:0]  state;
    logic [CW-1:0] cnt;
    logic [3:0]  dec_ctrl;
    logic        dec_ill, dec_m;
    logic [2:0]  f3;
    logic [XLEN-1:0] alu_res;
    logic        eq, slt, sltu;
    logic [SHW-1:0] sh;

    assign f3        = funct[2:0];
    assign sh        = op_b[SHW-1:0];
    assign eq        = (op_a == op_b);
    assign slt       = ($signed(op_a) < $signed(op_b));
    assign sltu      = (op_a < op_b);
    assign in_ready  = (state == S_IDLE) && !reset;
    assign out_valid = (state == S_DONE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_ctrl = C_NONE;
        dec_ill  = 1'b0;
        dec_m    = 1'b0;
        case (alu_op)
            4'b0000, 4'b0010, 4'b0111, 4'b1000: dec_ctrl = C_ADD;
            4'b0011: if (f3 <= 3'b010) dec_ctrl = C_ADD; else dec_ill = 1'b1;
            4'b0101: dec_ctrl = C_PASSB;
            4'b0110: dec_ctrl = C_SUB;
            4'b0001, 4'b0100: begin
                if (alu_op == 4'b0100 && funct_m) begin
                    if (ENABLE_M && !funct[3]) begin
                        dec_m    = 1'b1;
                        dec_ctrl = f3[2] ? C_DIV : C_MUL;
                    end else begin
                        dec_ill = 1'b1;
                    end
                end else begin
                    case (f3)
                        3'b000: dec_ctrl = (alu_op == 4'b0100 && funct[3]) ? C_SUB : C_ADD;
                        3'b001: if (alu_op == 4'b0001 && funct[3]) dec_ill = 1'b1; else dec_ctrl = C_LSL;
                        3'b010: dec_ctrl = C_SLT;
                        3'b011: dec_ctrl = C_SLTU;
                        3'b100: dec_ctrl = C_XOR;
                        3'b101: dec_ctrl = funct[3] ? C_RSA : C_RSL;
                        3'b110: dec_ctrl = C_OR;
                        default: dec_ctrl = C_AND;
                    endcase
                end
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) dec_ctrl = C_NONE;
    end

    always_comb begin
        alu_res = '0;
        case (dec_ctrl)
            C_AND:   alu_res = op_a & op_b;
            C_OR:    alu_res = op_a | op_b;
            C_XOR:   alu_res = op_a ^ op_b;
            C_LSL:   alu_res = op_a << sh;
            C_RSL:   alu_res = op_a >> sh;
            C_RSA:   alu_res = $unsigned($signed(op_a) >>> sh);
            C_ADD:   alu_res = op_a + op_b;
            C_SUB:   alu_res = op_a - op_b;
            C_SLT:   alu_res = {{(XLEN-1){1'b0}}, slt};
            C_SLTU:  alu_res = {{(XLEN-1){1'b0}}, sltu};
            C_PASSB: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Operand signedness per funct3: MUL/MULH/MULHSU/DIV/REM treat op_a as signed.
    logic a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    assign a_signed = f3[2] ? !f3[0] : (f3[1:0] != 2'b11);
    assign b_signed = f3[2] ? !f3[0] : !f3[1];
    assign sa       = a_signed && op_a[XLEN-1];
    assign sb       = b_signed && op_b[XLEN-1];
    assign mag_a    = sa ? -op_a : op_a;
    assign mag_b    = sb ? -op_b : op_b;

    logic [2:0]        f3_q;
    logic              sa_q, sb_q, divz_q;
    logic [XLEN-1:0]   a_q, mplier, rem, quo, dsor;
    logic [2*XLEN-1:0] acc, mcand;

    logic [2*XLEN-1:0] acc_nxt, prod_fix;
    logic [XLEN:0]     shifted, diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_nxt, quo_nxt, quo_fix, rem_fix, m_final;

    always_comb begin
        acc_nxt  = acc + (mplier[0] ? mcand : '0);
        shifted  = {rem, quo[XLEN-1]};
        diff     = shifted - {1'b0, dsor};
        q_bit    = !diff[XLEN];
        rem_nxt  = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nxt  = {quo[XLEN-2:0], q_bit};
        prod_fix = (sa_q ^ sb_q) ? -acc_nxt : acc_nxt;
        quo_fix  = divz_q ? '1  : ((sa_q ^ sb_q) ? -quo_nxt : quo_nxt);
        rem_fix  = divz_q ? a_q : (sa_q ? -rem_nxt : rem_nxt);
        case (f3_q)
            3'b000:         m_final = prod_fix[XLEN-1:0];
            3'b100, 3'b101: m_final = quo_fix;
            3'b110, 3'b111: m_final = rem_fix;
            default:        m_final = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // NOTE: iteration datapath registers carry no reset; the FSM never consumes them before loading.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready && dec_m) begin
            f3_q   <= f3;
            sa_q   <= sa;
            sb_q   <= sb;
            divz_q <= (op_b == '0);
            a_q    <= op_a;
            acc    <= '0;
            mcand  <= {{XLEN{1'b0}}, mag_a};
            mplier <= mag_b;
            rem    <= '0;
            quo    <= mag_a;
            dsor   <= mag_b;
        end else if (state == S_BUSY) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_nxt;
            quo    <= quo_nxt;
        end
    end

    // Flags and code are latched at accept and stay put until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            result   <= '0;
            alu_ctrl <= C_NONE;
            zero     <= 1'b0;
            lt       <= 1'b0;
            ltu      <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid && in_ready) begin
                    alu_ctrl <= dec_ctrl;
                    illegal  <= dec_ill;
                    zero     <= !dec_ill && eq;
                    lt       <= !dec_ill && slt;
                    ltu      <= !dec_ill && sltu;
                    if (dec_m) begin
                        state <= S_BUSY;
                        cnt   <= CW'(XLEN);
                    end else begin
                        state  <= S_DONE;
                        result <= alu_res;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= S_DONE;
                        result <= m_final;
                    end
                end
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: scoreboard of expected results, immediate-assertion checks.
module tb_alu_exec_unit;
    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1, funct_m = 1'b0;
    logic        nv_valid = 1'b0, nv_out_ready = 1'b1;
    logic [3:0]  alu_op = '0, funct = '0;
    logic [31:0] op_a = '0, op_b = '0;

    logic        in_ready, out_valid, zero, lt, ltu, illegal;
    logic [31:0] result;
    logic [3:0]  alu_ctrl;
    logic        nv_in_ready, nv_out_valid, nv_zero, nv_lt, nv_ltu, nv_illegal;
    logic [31:0] nv_result;
    logic [3:0]  nv_alu_ctrl;

    alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .funct_m(funct_m), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .alu_ctrl(alu_ctrl),
        .zero(zero), .lt(lt), .ltu(ltu), .illegal(illegal));

    alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .reset(reset), .in_valid(nv_valid), .in_ready(nv_in_ready),
        .alu_op(alu_op), .funct(funct), .funct_m(funct_m), .op_a(op_a), .op_b(op_b),
        .out_valid(nv_out_valid), .out_ready(nv_out_ready), .result(nv_result),
        .alu_ctrl(nv_alu_ctrl), .zero(nv_zero), .lt(nv_lt), .ltu(nv_ltu), .illegal(nv_illegal));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  ctrl;
        logic        ill;
        logic        zero, lt, ltu;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, push its expectation, then pop and compare when the DUT responds.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] fn,
                          input logic fm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic [3:0] ctrl, input logic ill,
                          input int lat, input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        alu_op = op; funct = fn; funct_m = fm; op_a = a; op_b = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        e.result = res; e.ctrl = ctrl; e.ill = ill; e.lat = lat;
        e.zero = !ill && (a == b);
        e.lt   = !ill && ($signed(a) < $signed(b));
        e.ltu  = !ill && (a < b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        funct = 4'($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 200);
        e = sb.pop_front();
        check({tag, " latency"}, 32'(n), 32'(e.lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " hold result"}, result, e.result);
        end
        check({tag, " result"}, result, e.result);
        check({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'(e.ctrl));
        check({tag, " illegal"}, 32'(illegal), 32'(e.ill));
        if (!e.ill) check({tag, " flags"}, {29'd0, zero, lt, ltu}, {29'd0, e.zero, e.lt, e.ltu});
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, " next in_ready"}, 32'(in_ready), 32'd1);
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int hi_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", result, 32'd0);
        check("rst alu_ctrl", 32'(alu_ctrl), 32'hF);
        check("rst flags", {28'd0, zero, lt, ltu, illegal}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add",     4'b0100, 4'b0000, 0, 32'd5,        32'd7,        32'd12,       4'b0110, 0, 1, 0);
        run_op("sub",     4'b0100, 4'b1000, 0, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b0111, 0, 1, 0);
        run_op("slt",     4'b0100, 4'b0010, 0, 32'hFFFFFFFF, 32'd1,        32'd1,        4'b1000, 0, 1, 0);
        run_op("sltu",    4'b0100, 4'b0011, 0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1001, 0, 1, 0);
        run_op("branch",  4'b0110, 4'b0000, 0, 32'd9,        32'd9,        32'd0,        4'b0111, 0, 1, 0);
        run_op("sra",     4'b0100, 4'b1101, 0, 32'h80000000, 32'h00000024, 32'hF8000000, 4'b0101, 0, 1, 0);
        run_op("slli",    4'b0001, 4'b0001, 0, 32'h00000003, 32'h00000021, 32'h00000006, 4'b0011, 0, 1, 0);
        run_op("lui",     4'b0101, 4'b0111, 0, 32'h11111111, 32'h12345000, 32'h12345000, 4'b1010, 0, 1, 0);
        run_op("xor_bp",  4'b0001, 4'b0100, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 4'b0010, 0, 1, 3);
        run_op("mulhu",   4'b0100, 4'b0011, 1, 32'h00010000, 32'h00010000, 32'h00000001, 4'b1011, 0, 33, 0);
        run_op("mul",     4'b0100, 4'b0000, 1, 32'h00010000, 32'h00010000, 32'h00000000, 4'b1011, 0, 33, 0);
        run_op("mulh",    4'b0100, 4'b0001, 1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 4'b1011, 0, 33, 0);
        run_op("divu0",   4'b0100, 4'b0101, 1, 32'd7,        32'd0,        32'hFFFFFFFF, 4'b1100, 0, 33, 0);
        run_op("remu0",   4'b0100, 4'b0111, 1, 32'd7,        32'd0,        32'd7,        4'b1100, 0, 33, 0);
        run_op("div0s",   4'b0100, 4'b0100, 1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 4'b1100, 0, 33, 0);
        run_op("rem0s",   4'b0100, 4'b0110, 1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 4'b1100, 0, 33, 0);
        run_op("div_ovf", 4'b0100, 4'b0100, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1100, 0, 33, 0);
        run_op("rem_ovf", 4'b0100, 4'b0110, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        4'b1100, 0, 33, 0);
        run_op("div_m7",  4'b0100, 4'b0100, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'b1100, 0, 33, 0);
        run_op("rem_m7",  4'b0100, 4'b0110, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'b1100, 0, 33, 0);
        run_op("ill_imm", 4'b0001, 4'b1001, 0, 32'd1,        32'd2,        32'd0,        4'b1111, 1, 1, 0);
        run_op("ill_op",  4'b1001, 4'b0000, 0, 32'd1,        32'd2,        32'd0,        4'b1111, 1, 1, 0);
        run_op("ill_st",  4'b0011, 4'b0011, 0, 32'd1,        32'd2,        32'd0,        4'b1111, 1, 1, 0);
        run_op("ill_m7",  4'b0100, 4'b1000, 1, 32'd1,        32'd2,        32'd0,        4'b1111, 1, 1, 0);

        // M op on the instance built without RV32M support.
        check("nom in_ready", 32'(nv_in_ready), 32'd1);
        alu_op = 4'b0100; funct = 4'b0000; funct_m = 1'b1; op_a = 32'd6; op_b = 32'd7;
        nv_valid = 1'b1;
        @(posedge clk);
        #1 nv_valid = 1'b0;
        @(negedge clk);
        check("nom out_valid", 32'(nv_out_valid), 32'd1);
        check("nom illegal", 32'(nv_illegal), 32'd1);
        check("nom result", nv_result, 32'd0);
        check("nom alu_ctrl", 32'(nv_alu_ctrl), 32'hF);

        // Reset ten cycles into a DIV: nothing may be emitted for it.
        @(negedge clk);
        alu_op = 4'b0100; funct = 4'b0100; funct_m = 1'b1; op_a = 32'd100; op_b = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid in_ready", 32'(in_ready), 32'd0);
        check("rst_mid out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_mid ready after", 32'(in_ready), 32'd1);
        hi_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) hi_cnt++;
        end
        check("rst_mid no output", 32'(hi_cnt), 32'd0);
        run_op("add_post", 4'b0000, 4'b0010, 0, 32'd100, 32'hFFFFFFFC, 32'd96, 4'b0110, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised ALU-control-plus-execute stage that replaces the purely combinational ALU control decoder for multi-cycle operation. It decodes `alu_op`/`funct` into an ALU control code and executes the operation on XLEN-bit operands. Base RV32I operations complete in one cycle; optional RV32M multiply/divide operations are iterative. Results leave through a valid/ready handshake, and the block sits between the register-read and writeback/branch logic of the core.

## Interface
- `XLEN`, 32: operand/result width, at least 8 and a power of two.
- `ENABLE_M`, 1: when 1, RV32M ops are decoded; when 0, they are flagged illegal.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: reset, synchronous and active-high.
- `in_valid` in 1: request valid.
- `in_ready` out 1: block can accept a request; equals (state==IDLE && !reset).
- `alu_op` in 4: main-decoder class. 0000 load, 0001 OP-IMM, 0010 AUIPC, 0011 store, 0100 OP, 0101 LUI, 0110 branch, 0111 JALR, 1000 JAL.
- `funct` in 4: {funct7[5], funct3}.
- `funct_m` in 1: funct7[0], which selects RV32M when `alu_op`=0100.
- `op_a`, `op_b` in XLEN: operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out XLEN: registered result.
- `alu_ctrl` out 4: registered decoded code. AND 0000, OR 0001, XOR 0010, LSL 0011, RSL 0100, RSA 0101, ADD 0110, SUB 0111, SLT 1000, SLTU 1001, PASSB 1010, MUL 1011, DIV 1100, NONE 1111.
- `zero`, `lt`, `ltu` out 1: registered flags from op_a−op_b: equal, signed less-than, unsigned less-than.
- `illegal` out 1: registered flag for an undecodable request.

## Operation
- **Decode (alu_op → code).**
  - Load, AUIPC, JALR, JAL → ADD.
  - Store → ADD for funct3 ∈ {000,001,010}; otherwise illegal.
  - LUI → PASSB.
  - Branch → SUB.
  - OP-IMM / OP with funct3:
    - 000 → ADD; for OP only, funct[3]=1 selects SUB.
    - 001 → LSL; for OP-IMM, funct[3]=1 is illegal.
    - 010 → SLT.
    - 011 → SLTU.
    - 100 → XOR.
    - 101 → RSL, or RSA when funct[3]=1.
    - 110 → OR.
    - 111 → AND.
  - `alu_op` 1001–1111 → illegal.
- **M decode.** OP with funct_m=1 and ENABLE_M=1 → MUL (funct3 0xx) or DIV (funct3 1xx); funct[3] must be 0, otherwise illegal. With ENABLE_M=0 → illegal.
- **Shifts.** Use op_b[log2(XLEN)-1:0].
- **SLT/SLTU.** Result is zero-extended lt/ltu.
- **Arithmetic width.** ADD/SUB wrap modulo 2^XLEN.
- **Multiply.** Shift-add, one bit per cycle, on magnitudes with sign fixed at completion. funct3 000 MUL gives the low half; 001 MULH, 010 MULHSU, 011 MULHU give the high half of the 2·XLEN product.
- **Divide.** Restoring, one quotient bit per cycle, on magnitudes. 100 DIV, 101 DIVU, 110 REM, 111 REMU. Remainder sign follows the dividend.
- **Divide by zero.** Quotient is all ones; remainder is op_a.
- **Signed overflow.** DIV with op_a=min and op_b=−1 gives quotient min and remainder 0. Both this case and divide-by-zero still take the full iterative latency.
- **Illegal requests.** result=0, alu_ctrl=NONE, illegal=1. The transaction completes normally through the handshake.
- **FSM: IDLE / BUSY / DONE.**
  - IDLE → DONE on accept of a single-cycle op or an illegal request.
  - IDLE → BUSY on accept of an M op; the iteration counter is loaded with XLEN.
  - BUSY → DONE when the counter reaches 0.
  - DONE → IDLE when out_ready=1.
- **Output stability.** result, alu_ctrl and flags are captured when DONE is entered and held stable until the handshake completes.

## Timing
- **Reset values.** state=IDLE, in_ready=0 while reset is high, out_valid=0, result=0, alu_ctrl=NONE, zero=lt=ltu=illegal=0.
- **Reset mid-operation.** Reset in BUSY or DONE aborts immediately; nothing is emitted for the aborted request.
- **Accept.** A request is accepted at a rising edge with in_valid && in_ready. Operands and funct are sampled only at accept.
- **Latency.** out_valid rises 1 cycle after accept for single-cycle and illegal ops, and XLEN+1 cycles after accept for M ops.
- **Back-to-back throughput.** In DONE with out_ready=1, the next in_ready=1 occurs the following cycle. Peak rate is one op per 2 cycles.
- **Backpressure.** With out_ready=0, out_valid stays high, outputs are stable, and in_ready stays 0.
- **Input stability.** Changes on in_valid or operands while busy have no effect.

## Test plan
- **ADD.** alu_op=0100, funct=0000, 5+7 → out_valid 1 cycle after accept, result=12, alu_ctrl=0110, zero=0.
- **SLT/SLTU.** op_a=0xFFFFFFFF, op_b=1: SLT → result=1, lt=1; SLTU → result=0, ltu=0. Branch with op_a=op_b=9 → zero=1.
- **Multiply.** op_a=op_b=0x00010000: MULHU → 0x00000001, MUL → 0x00000000, out_valid exactly 33 cycles after accept. MULH with −2×3 → 0xFFFFFFFF.
- **Divide corners.** DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0. DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
- **Illegal decode.** OP-IMM funct=1001 → illegal=1, result=0, alu_ctrl=1111. With ENABLE_M=0, an M op → illegal=1.
- **Handshake/reset.**
  - Hold out_ready=0 for 3 cycles → result stable, in_ready=0.
  - Assert reset 10 cycles into a DIV → out_valid never rises; in_ready=1 on the first cycle after reset deasserts.
